// File: rtl/arb_mux_pkg.sv
// arb_mux_pkg: shared types and defaults for the arb_mux2 arbitrated multiplexer.
//   estado_t : arbiter states (IDLE, SERVE0, SERVE1)
//   ANCHO_DEF, RAFAGA_DEF : default data width and burst length
//   cnt_w()  : burst counter width, clog2 with a floor of one bit
package arb_mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2
    } estado_t;

    localparam int ANCHO_DEF  = 8;
    localparam int RAFAGA_DEF = 4;

    // A counter for RAFAGA=1 still needs one bit so the port has a width.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_v3.sv
// mux_v3: 2:1 datapath multiplexer.
//   d0, d1 : data inputs (ANCHO bits)
//   s      : select, 0 -> d0, 1 -> d1
//   q      : selected data (ANCHO bits)
module mux_v3 #(
    parameter int ANCHO = 8
) (
    input  logic [ANCHO-1:0] d0,
    input  logic [ANCHO-1:0] d1,
    input  logic             s,
    output logic [ANCHO-1:0] q
);

    assign q = s ? d1 : d0;

endmodule

// File: rtl/arb_mux2.sv
// arb_mux2: two-requester arbitrated multiplexer with one registered output.
// Round-robin grant with at most RAFAGA consecutive words per grant while the
// other port waits. The grant drives the select of mux_v3; the mux output is
// captured in the q register.
//
// Ports:
//   clk, rst_n     : rising-edge clock, asynchronous active-low reset
//   d0, v0 / r0    : port 0 data, valid in / ready out
//   d1, v1 / r1    : port 1 data, valid in / ready out
//   q, qv / qr     : registered output data, valid out / downstream ready in
//   s              : current grant (mux select)
//
// Build option:
//   ARB_MUX_FIXED_PRIO_EN : port 0 has fixed priority; SERVE0 never yields on
//                           burst expiry, SERVE1 yields whenever v0 is high at
//                           a transfer. The last-served register is dropped.
module arb_mux2
    import arb_mux_pkg::*;
#(
    parameter int ANCHO  = ANCHO_DEF,
    parameter int RAFAGA = RAFAGA_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ANCHO-1:0] d0,
    input  logic             v0,
    output logic             r0,
    input  logic [ANCHO-1:0] d1,
    input  logic             v1,
    output logic             r1,
    output logic [ANCHO-1:0] q,
    output logic             qv,
    input  logic             qr,
    output logic             s
);

    localparam int            CW      = cnt_w(RAFAGA);
    localparam logic [CW-1:0] CNT_MAX = CW'(RAFAGA - 1);

    estado_t          est_q, est_d;
    logic             s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [ANCHO-1:0] q_q, mux_q;
    logic             qv_q;

    logic libre, t0, t1, xfer, fin;
    logic cur, vc, vo, pick, yield;

`ifndef ARB_MUX_FIXED_PRIO_EN
    logic last_q, last_d;
`endif

    mux_v3 #(.ANCHO(ANCHO)) u_mux (
        .d0 (d0),
        .d1 (d1),
        .s  (s_q),
        .q  (mux_q)
    );

    assign libre = !qv_q || qr;
    assign r0    = (est_q == SERVE0) && libre;
    assign r1    = (est_q == SERVE1) && libre;
    assign t0    = r0 && v0;
    assign t1    = r1 && v1;
    assign xfer  = t0 || t1;
    assign fin   = (cnt_q == CNT_MAX);

    // Port currently being served, its valid, and the other port's valid.
    assign cur = (est_q == SERVE1);
    assign vc  = cur ? v1 : v0;
    assign vo  = cur ? v0 : v1;

`ifdef ARB_MUX_FIXED_PRIO_EN
    assign pick  = !v0;
    assign yield = cur && v0;
`else
    // On a tie the port that was not served last wins.
    assign pick  = (v0 && v1) ? !last_q : v1;
    assign yield = fin && vo;
`endif

    always_comb begin
        est_d = est_q;
        s_d   = s_q;
        cnt_d = cnt_q;
`ifndef ARB_MUX_FIXED_PRIO_EN
        last_d = last_q;
`endif
        case (est_q)
            IDLE: begin
                if (v0 || v1) begin
                    s_d   = pick;
                    est_d = pick ? SERVE1 : SERVE0;
                    cnt_d = '0;
                end
            end
            SERVE0, SERVE1: begin
                if (!vc) begin
                    // Requester released: hand over or go idle regardless of qr.
`ifndef ARB_MUX_FIXED_PRIO_EN
                    last_d = cur;
`endif
                    cnt_d = '0;
                    if (vo) begin
                        est_d = cur ? SERVE0 : SERVE1;
                        s_d   = !cur;
                    end else begin
                        est_d = IDLE;
                    end
                end else if (xfer) begin
                    if (yield) begin
`ifndef ARB_MUX_FIXED_PRIO_EN
                        last_d = cur;
`endif
                        est_d = cur ? SERVE0 : SERVE1;
                        s_d   = !cur;
                        cnt_d = '0;
                    end else if (fin) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                est_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            est_q <= IDLE;
            s_q   <= 1'b0;
            cnt_q <= '0;
            q_q   <= '0;
            qv_q  <= 1'b0;
        end else begin
            est_q <= est_d;
            s_q   <= s_d;
            cnt_q <= cnt_d;
            if (xfer) begin
                q_q  <= mux_q;
                qv_q <= 1'b1;
            end else if (qr && qv_q) begin
                qv_q <= 1'b0;
            end
        end
    end

`ifndef ARB_MUX_FIXED_PRIO_EN
    // Reset to 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign q  = q_q;
    assign qv = qv_q;
    assign s  = s_q;

endmodule

// File: tb/tb_arb_mux2.sv
// tb_arb_mux2: self-checking bench for arb_mux2 (ANCHO=8, RAFAGA=4).
// Directed scenarios plus a randomized run, every cycle compared against a
// grant/burst reference model.
module tb_arb_mux2;

    localparam int ANCHO  = 8;
    localparam int RAFAGA = 4;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [ANCHO-1:0] d0    = '0;
    logic [ANCHO-1:0] d1    = '0;
    logic             v0    = 1'b0;
    logic             v1    = 1'b0;
    logic             qr    = 1'b0;
    logic             r0, r1, qv, s;
    logic [ANCHO-1:0] q;

    always #5 clk = ~clk;

    arb_mux2 #(.ANCHO(ANCHO), .RAFAGA(RAFAGA)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .d0    (d0),
        .v0    (v0),
        .r0    (r0),
        .d1    (d1),
        .v1    (v1),
        .r1    (r1),
        .q     (q),
        .qv    (qv),
        .qr    (qr),
        .s     (s)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: owner (-1 = nobody), words granted in current burst,
    // previously served port, expected select and output register.
    int               owner, burst, prev, ms;
    logic [ANCHO-1:0] mq;
    bit               mqv;

    logic [ANCHO-1:0] outq[$];
    bit               seen_r0, seen_r1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner = -1;
        burst = 0;
        prev  = 1;
        ms    = 0;
        mq    = '0;
        mqv   = 1'b0;
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".r0"}, r0, (owner == 0) && (!mqv || qr));
        check_eq({tag, ".r1"}, r1, (owner == 1) && (!mqv || qr));
        check_eq({tag, ".s"},  s,  ms);
        check_eq({tag, ".qv"}, qv, mqv);
        check_eq({tag, ".q"},  q,  mq);
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_step();
        bit vin[2];
        bit moved, give;
        int o;
        vin[0] = v0;
        vin[1] = v1;
        moved  = 1'b0;
        if (owner >= 0 && (!mqv || qr) && vin[owner]) begin
            mq    = (owner == 1) ? d1 : d0;
            mqv   = 1'b1;
            moved = 1'b1;
        end else if (qr && mqv) begin
            mqv = 1'b0;
        end
        if (owner < 0) begin
            if (vin[0] || vin[1]) begin
`ifdef ARB_MUX_FIXED_PRIO_EN
                owner = vin[0] ? 0 : 1;
`else
                owner = (vin[0] && vin[1]) ? 1 - prev : (vin[0] ? 0 : 1);
`endif
                ms    = owner;
                burst = 0;
            end
        end else begin
            o = 1 - owner;
            if (!vin[owner]) begin
                prev  = owner;
                burst = 0;
                owner = vin[o] ? o : -1;
                if (owner >= 0) ms = owner;
            end else if (moved) begin
                burst++;
`ifdef ARB_MUX_FIXED_PRIO_EN
                give = (owner == 1) && vin[0];
`else
                give = (burst == RAFAGA) && vin[o];
`endif
                if (give) begin
                    prev  = owner;
                    owner = o;
                    ms    = o;
                    burst = 0;
                end else if (burst == RAFAGA) begin
                    burst = 0;
                end
            end
        end
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic cyc(input logic a0, input logic [ANCHO-1:0] x0,
                       input logic a1, input logic [ANCHO-1:0] x1,
                       input logic rdy, input string tag);
        v0 = a0; d0 = x0; v1 = a1; d1 = x1; qr = rdy;
        @(negedge clk);
        compare_all(tag);
        seen_r0 = r0;
        seen_r1 = r1;
        if (qv && qr) outq.push_back(q);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst.q",  q,  0);
        check_eq("rst.qv", qv, 0);
        check_eq("rst.r0", r0, 0);
        check_eq("rst.r1", r1, 0);
        check_eq("rst.s",  s,  0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    function automatic logic [ANCHO-1:0] exp_word(input int j);
        int blk;
        int idx;
        blk = j / RAFAGA;
        idx = j % RAFAGA;
        if (blk % 2 == 0) return ANCHO'(blk / 2 * RAFAGA + idx);
        return ANCHO'(8'h80 + blk / 2 * RAFAGA + idx);
    endfunction

    initial begin
        logic             rdy;
        logic [ANCHO-1:0] c0, c1, held;
        int               n1;

        model_reset();
        @(posedge clk);
        #1;
        check_eq("init.q",  q,  0);
        check_eq("init.qv", qv, 0);
        check_eq("init.r0", r0, 0);
        check_eq("init.r1", r1, 0);
        check_eq("init.s",  s,  0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Single requester: word visible two cycles after v0 rises.
        cyc(1'b1, 8'd3, 1'b0, 8'd0, 1'b1, "t1");
        cyc(1'b1, 8'd3, 1'b0, 8'd0, 1'b1, "t1");
        check_eq("t1.q",  q,  3);
        check_eq("t1.qv", qv, 1);
        cyc(1'b1, 8'd5, 1'b0, 8'd0, 1'b1, "t1");
        cyc(1'b1, 8'd5, 1'b0, 8'd0, 1'b1, "t1");
        check_eq("t1.pre_rst_qv", qv, 1);

        // Reset mid-stream, then port 1 alone.
        do_reset();
        cyc(1'b0, 8'd0, 1'b1, 8'h44, 1'b1, "t2");
        check_eq("t2.s", s, 1);
        cyc(1'b0, 8'd0, 1'b1, 8'h44, 1'b1, "t2");
        check_eq("t2.q", q, 8'h44);
        cyc(1'b0, 8'd0, 1'b0, 8'd0, 1'b1, "t2");
        cyc(1'b0, 8'd0, 1'b0, 8'd0, 1'b1, "t2");

`ifndef ARB_MUX_FIXED_PRIO_EN
        // Both valid with a 5-cycle stall mid-burst; order must be RAFAGA-word blocks.
        do_reset();
        c0 = 8'h00;
        c1 = 8'h80;
        held = '0;
        outq.delete();
        for (int k = 0; k < 40 && outq.size() < 16; k++) begin
            rdy = !(k >= 11 && k < 16);
            if (k == 11) held = q;
            cyc(1'b1, c0, 1'b1, c1, rdy, "t3");
            if (k >= 11 && k < 16) begin
                check_eq("t3.hold_q",  q,  held);
                check_eq("t3.hold_qv", qv, 1);
                check_eq("t3.hold_r0", seen_r0, 0);
            end
            if (seen_r0) c0++;
            if (seen_r1) c1++;
        end
        check_eq("t3.count", outq.size(), 16);
        for (int j = 0; j < 16; j++) begin
            if (j < outq.size()) check_eq($sformatf("t3.word%0d", j), outq[j], exp_word(j));
        end

        // Early release of port 0 after two words.
        do_reset();
        c0 = 8'h10;
        c1 = 8'h90;
        n1 = 0;
        for (int k = 0; k < 11; k++) begin
            cyc((k < 3) || (k >= 5), c0, 1'b1, c1, 1'b1, "t4");
            if (k == 3) check_eq("t4.s_switch", s, 1);
            if (seen_r0 && v0) c0++;
            if (seen_r1) begin
                c1++;
                if (k >= 4) n1++;
            end
        end
        check_eq("t4.p1_words", n1, RAFAGA);
`else
        // Fixed priority: port 1 never served while port 0 stays valid.
        do_reset();
        c0 = 8'h00;
        c1 = 8'h80;
        n1 = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(1'b1, c0, 1'b1, c1, 1'b1, "tfp");
            check_eq("tfp.r1", seen_r1, 0);
            if (seen_r0) begin
                c0++;
                n1++;
            end
        end
        check_eq("tfp.p0_words", n1, 19);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            cyc($urandom_range(0, 3) != 0, ANCHO'($urandom),
                $urandom_range(0, 3) != 0, ANCHO'($urandom),
                $urandom_range(0, 4) != 0, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/arb_mux2.md
# arb_mux2

- Two-requester arbitrated multiplexer.
- Two producers, each with a valid/ready stream; one registered valid/ready output.
- Round-robin arbitration with a bounded burst length per grant.
- Drives the select of the team's 2:1 datapath mux and places one output register behind it.
- Used wherever two sources share one downstream consumer.

## Interface
- ANCHO, 8: data width in bits.
- RAFAGA, 4: max consecutive transfers per grant when the other port is waiting (≥1).

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- d0  in  ANCHO  port 0 data
- v0  in  1  port 0 valid
- r0  out  1  port 0 ready
- d1  in  ANCHO  port 1 data
- v1  in  1  port 1 valid
- r1  out  1  port 1 ready
- q  out  ANCHO  registered output data
- qv  out  1  output valid
- qr  in  1  downstream ready
- s  out  1  current grant, which is the mux select

## Operation
- **States:** IDLE, SERVE0, SERVE1. Registers: grant `s`, burst counter `cnt` (clog2(RAFAGA) bits), `last` (last port served).
- **Slot free:** `libre = !qv || qr`.
- **Ready:** `r_i = (state==SERVE_i) && libre`.
- **Transfer on port i:** `r_i && v_i`. At the next edge, `q <= d_i`, `qv <= 1`.
- **Drain:** with no transfer, `qr && qv` clears `qv`. `q` holds its value.
- **IDLE:**
  - If neither valid: stay.
  - If both valid: go to SERVE of the port != `last`.
  - Otherwise: go to SERVE of the valid port.
  - On entry: `cnt <= 0`, `s` <= the chosen port.
- **SERVE_i:**
  - **v_i low:** if the other port is valid, go to SERVE_other; else go to IDLE. Update `last <= i`.
  - **Transfer with cnt == RAFAGA-1:** if the other port is valid, go to SERVE_other with `cnt <= 0` and `last <= i`. Otherwise stay with `cnt <= 0`.
  - **Other transfer:** `cnt <= cnt+1`.
- **Backpressure:** `qr` low with `qv` high holds `q`, `qv` and `cnt`. No transfer, no state change unless v_i drops.
- **Select output:** `s` changes only on a state transition and holds its value in IDLE.
- **Data rule:** no arithmetic on data. Data passes unmodified.

## Timing
- **Reset values:** q=0, qv=0, r0=0, r1=0, s=0; state IDLE, cnt=0, last=1 (so port 0 wins first).
- **Async reset mid-transfer:** drops `qv` immediately. Any pending datum is lost.
- **Latency from IDLE:** v_i rises at cycle n → SERVE_i at n+1 → `r_i` high at n+1 → `q`/`qv` valid at n+2.
- **Inside SERVE_i:** one word per cycle while `qr` stays high (full throughput).
- **Grant switch cost:** zero idle cycles. Same-cycle switch at burst expiry; first `r_other` is in the next cycle.
- **Both valid, continuous:** the ports alternate in bursts of exactly RAFAGA words.
- **RAFAGA = 1:** strict word-by-word alternation when both ports are valid.

## Configuration
- **ARB_MUX_FIXED_PRIO_EN defined:**
  - IDLE always chooses port 0 when v0 is high.
  - SERVE0 never yields on burst expiry; only v0 low leaves it.
  - SERVE1 yields to port 0 at burst expiry or whenever v0 is high at a transfer.
  - `last` is unused.
- **Undefined:** round-robin behaviour as specified above.

## Structure
- **arb_mux_pkg:**
  - `estado_t` enum (IDLE, SERVE0, SERVE1)
  - localparam defaults for ANCHO and RAFAGA
  - `cnt` width function (clog2 with minimum 1)
- **Sub-module:** the existing `mux_v3` (ports d0, d1, s, q; parameter ANCHO) instantiated for the data path, select tied to `s`, output feeding the `q` register.
- FSM, counter and output register stay in `arb_mux2`.

## Test plan
- **Reset:** assert rst_n=0 mid-stream with qv=1 → q=0, qv=0, r0=r1=0, s=0 immediately. After release with v1=1 only, SERVE1 starts one cycle later.
- **Single requester:** v0=1, d0=3, qr=1 → q=3, qv=1 two cycles after v0 rises; `r1` never asserts.
- **Both valid, RAFAGA=4, qr=1:** d0/d1 incrementing → output order is 4 words from port 0, then 4 from port 1, repeating, with no bubble cycles.
- **Backpressure:** qr=0 for 5 cycles mid-burst → q and qv stable, r0=0, cnt unchanged. After qr=1 the burst finishes its remaining count.
- **Early release:** v0 drops after 2 words while v1=1 → s switches to 1 next cycle and port 1 is served with cnt=0.
- **ARB_MUX_FIXED_PRIO_EN:** both valid continuously → only port 0 is served, with r1=0 throughout.
